// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and defaults for the fetch-stage PC redirect unit.
// State encoding and the default reset PC live here so every file agrees on them.
package pc_redirect_unit_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Redirect-request and fetch-address bundle between the pipeline and the PC unit.
// Optional PC_REDIRECT_CNT_EN adds the redirect_count output.
interface pc_redirect_unit_if #(
   parameter int unsigned IMEM_AW = 12
);
   logic               stall;
   logic               br_taken;
   logic [31:0]        br_pc;
   logic [31:0]        br_offset;
   logic               jump_en;
   logic [31:0]        jump_target;
   logic               jr_en;
   logic [31:0]        jr_target;
   logic [31:0]        pc;
   logic [IMEM_AW-1:0] imem_addr;
   logic               flush;
`ifdef PC_REDIRECT_CNT_EN
   logic [31:0]        redirect_count;
`endif

   modport master (
      output stall, br_taken, br_pc, br_offset, jump_en, jump_target, jr_en, jr_target,
`ifdef PC_REDIRECT_CNT_EN
      input  redirect_count,
`endif
      input  pc, imem_addr, flush
   );

   modport slave (
      input  stall, br_taken, br_pc, br_offset, jump_en, jump_target, jr_en, jr_target,
`ifdef PC_REDIRECT_CNT_EN
      output redirect_count,
`endif
      output pc, imem_addr, flush
   );

endinterface

// File: rtl/pc_redirect_unit_pc_next_sel.sv
// Combinational next-PC priority mux: jr > jump > taken branch > stall hold > pc+1.
// All arithmetic is plain 32-bit modulo 2^32; offsets arrive already sign-extended.
module pc_next_sel
   import pc_redirect_unit_pkg::*;
(
   input  logic [31:0] i_pc,
   input  logic        i_stall,
   input  logic        i_br_taken,
   input  logic [31:0] i_br_pc,
   input  logic [31:0] i_br_offset,
   input  logic        i_jump_en,
   input  logic [31:0] i_jump_target,
   input  logic        i_jr_en,
   input  logic [31:0] i_jr_target,
   output logic [31:0] o_next_pc,
   output logic        o_redirect
);

   logic [31:0] w_br_dest;
   logic [31:0] w_seq_pc;

   assign w_br_dest  = i_br_pc + 32'd1 + i_br_offset;
   assign w_seq_pc   = i_pc + 32'd1;
   assign o_redirect = i_jr_en | i_jump_en | i_br_taken;

   always_comb begin
      o_next_pc = w_seq_pc;
      if (i_jr_en)         o_next_pc = i_jr_target;
      else if (i_jump_en)  o_next_pc = i_jump_target;
      else if (i_br_taken) o_next_pc = w_br_dest;
      else if (i_stall)    o_next_pc = i_pc;
   end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register, RUN/HOLD/FLUSH state machine and flush pulse generation.
// Define PC_REDIRECT_CNT_EN to add the free-running redirect_count output.
module pc_redirect_unit
   import pc_redirect_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned IMEM_AW  = 12
) (
   input logic               clock,
   input logic               reset,
   pc_redirect_unit_if.slave bus
);

   logic [31:0] r_pc;
   state_t      r_state;
   logic [31:0] w_next_pc;
   logic        w_redirect;

   pc_next_sel u_next_sel (
      .i_pc          (r_pc),
      .i_stall       (bus.stall),
      .i_br_taken    (bus.br_taken),
      .i_br_pc       (bus.br_pc),
      .i_br_offset   (bus.br_offset),
      .i_jump_en     (bus.jump_en),
      .i_jump_target (bus.jump_target),
      .i_jr_en       (bus.jr_en),
      .i_jr_target   (bus.jr_target),
      .o_next_pc     (w_next_pc),
      .o_redirect    (w_redirect)
   );

   // A redirect overrides a simultaneous stall: the stalled instruction is wrong-path.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc    <= RESET_PC;
         r_state <= RUN;
      end else begin
         r_pc <= w_next_pc;
         if (w_redirect)     r_state <= FLUSH;
         else if (bus.stall) r_state <= HOLD;
         else                r_state <= RUN;
      end
   end

   // Every state change flips at most the flush-decoding bit pattern cleanly, so this stays glitch-free.
   assign bus.flush     = (r_state == FLUSH);
   assign bus.pc        = r_pc;
   assign bus.imem_addr = r_pc[IMEM_AW-1:0];

`ifdef PC_REDIRECT_CNT_EN
   logic [31:0] r_redirect_count;

   always_ff @(posedge clock) begin
      if (reset)           r_redirect_count <= '0;
      else if (w_redirect) r_redirect_count <= r_redirect_count + 32'd1;
   end

   assign bus.redirect_count = r_redirect_count;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios plus randomized traffic
// against a behavioural model of the next-PC rules; honours PC_REDIRECT_CNT_EN.
module tb_pc_redirect_unit;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
   localparam int unsigned TB_AW       = 12;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   logic [31:0] m_pc;
   logic        m_flush;
   logic [31:0] m_cnt;

   pc_redirect_unit_if #(.IMEM_AW(TB_AW)) bus ();

   pc_redirect_unit #(
      .RESET_PC (TB_RESET_PC),
      .IMEM_AW  (TB_AW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model by the redirect/stall rules, then compare.
   task automatic step(input logic rst, input logic st,
                       input logic bt, input logic [31:0] bpc, input logic [31:0] boff,
                       input logic je, input logic [31:0] jt,
                       input logic jre, input logic [31:0] jrt);
      logic [31:0] nxt;
      logic        redir;
      reset           = rst;
      bus.stall       = st;
      bus.br_taken    = bt;
      bus.br_pc       = bpc;
      bus.br_offset   = boff;
      bus.jump_en     = je;
      bus.jump_target = jt;
      bus.jr_en       = jre;
      bus.jr_target   = jrt;
      redir = jre | je | bt;
      if (jre)     nxt = jrt;
      else if (je) nxt = jt;
      else if (bt) nxt = bpc + 32'd1 + boff;
      else if (st) nxt = m_pc;
      else         nxt = m_pc + 32'd1;
      @(posedge clock);
      #1;
      if (rst) begin
         m_pc    = TB_RESET_PC;
         m_flush = 1'b0;
         m_cnt   = 32'd0;
      end else begin
         m_pc    = nxt;
         m_flush = redir;
         if (redir) m_cnt = m_cnt + 32'd1;
      end
      chk("pc", bus.pc, m_pc);
      chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc[TB_AW-1:0]));
      chk("flush", 32'(bus.flush), 32'(m_flush));
`ifdef PC_REDIRECT_CNT_EN
      chk("redirect_count", bus.redirect_count, m_cnt);
`endif
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic do_stall();
      step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic do_jr(input logic [31:0] t, input logic st);
      step(1'b0, st, 1'b0, '0, '0, 1'b0, '0, 1'b1, t);
   endtask

   initial begin
      logic [31:0] cnt_before;
      checks = 0;
      errors = 0;
      m_pc = '0;
      m_flush = 1'b0;
      m_cnt = '0;
      #1;

      // Reset then four idle cycles.
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      chk("reset_pc_lit", bus.pc, 32'd0);
      chk("reset_flush_lit", 32'(bus.flush), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         idle();
         chk("idle_seq_lit", bus.pc, 32'(i));
      end

      // Backward branch from pc 10: 8 + 1 - 5 = 4.
      do_jr(32'd9, 1'b0);
      idle();
      chk("pre_branch_lit", bus.pc, 32'd10);
      step(1'b0, 1'b0, 1'b1, 32'd8, 32'hFFFF_FFFB, 1'b0, '0, 1'b0, '0);
      chk("branch_target_lit", bus.pc, 32'd4);
      chk("branch_flush_lit", 32'(bus.flush), 32'd1);
      idle();
      chk("branch_flush_end_lit", 32'(bus.flush), 32'd0);
      chk("after_branch_lit", bus.pc, 32'd5);

      // Jump and taken branch together: jump wins.
      step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 32'h100, 1'b0, '0);
      chk("jump_wins_lit", bus.pc, 32'h100);
      idle();
      chk("jump_seq_lit", bus.pc, 32'h101);

      // Three stall cycles at pc 7.
      do_jr(32'd6, 1'b0);
      idle();
      for (int i = 0; i < 3; i++) begin
         do_stall();
         chk("stall_hold_lit", bus.pc, 32'd7);
      end
      idle();
      chk("stall_resume_lit", bus.pc, 32'd8);

      // jr during the second stall cycle.
      do_stall();
      do_jr(32'h20, 1'b1);
      chk("jr_over_stall_lit", bus.pc, 32'h20);
      chk("jr_over_stall_flush_lit", 32'(bus.flush), 32'd1);
      do_stall();
      idle();
      chk("after_stall_jr_lit", bus.pc, 32'h21);

      // Wrap at the top of the address space.
      do_jr(32'hFFFF_FFFF, 1'b0);
      idle();
      chk("wrap_pc_lit", bus.pc, 32'd0);
      chk("wrap_imem_lit", 32'(bus.imem_addr), 32'd0);

      // Back-to-back redirects keep flush high each cycle.
`ifdef PC_REDIRECT_CNT_EN
      cnt_before = bus.redirect_count;
`else
      cnt_before = '0;
`endif
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 32'h40, 1'b0, '0);
      step(1'b0, 1'b0, 1'b1, 32'h40, 32'h10, 1'b0, '0, 1'b0, '0);
      chk("b2b_branch_lit", bus.pc, 32'h51);
      do_jr(32'h60, 1'b0);
      chk("b2b_flush_lit", 32'(bus.flush), 32'd1);
`ifdef PC_REDIRECT_CNT_EN
      chk("b2b_count_lit", bus.redirect_count - cnt_before, 32'd3);
`endif
      idle();
      chk("b2b_flush_end_lit", 32'(bus.flush), 32'd0);

      // Reset in the cycle right after a redirect.
      do_jr(32'h333, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h5, 32'h5, 1'b1, 32'h7, 1'b1, 32'h9);
      chk("reset_after_redirect_pc_lit", bus.pc, TB_RESET_PC);
      chk("reset_after_redirect_flush_lit", 32'(bus.flush), 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 2000; n++) begin
         logic [31:0] jrt;
         jrt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 5) == 0), $urandom, $urandom,
              ($urandom_range(0, 5) == 0), $urandom,
              ($urandom_range(0, 5) == 0), jrt);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Program-counter register and next-PC selector for the fetch stage of the five-stage processor. It consumes the 32-bit sign-extended branch offset and jump target produced by the decode-side sign extenders, chooses among sequential, branch, jump and jump-register successors, and holds the PC on pipeline stalls. It also emits a one-cycle flush pulse that kills the wrong-path instructions in the F/D and D/X latches after every taken redirect.

## Interface
- RESET_PC, default 0: PC value loaded on reset.
- IMEM_AW, default 12: instruction-memory address width.

- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard/multdiv stall; hold the PC.
- br_taken  in  1  branch in X resolved taken.
- br_pc  in  32  PC of that branch instruction.
- br_offset  in  32  sign-extended 17-bit immediate.
- jump_en  in  1  j/jal in X.
- jump_target  in  32  sign-extended 27-bit target.
- jr_en  in  1  jr in X.
- jr_target  in  32  register value for jr.
- pc  out  32  current fetch PC.
- imem_addr  out  IMEM_AW  pc[IMEM_AW-1:0].
- flush  out  1  kill F/D and D/X contents this cycle.

## Operation
- State machine with three states:
  - RUN: normal sequencing.
  - HOLD: the previous cycle was stalled.
  - FLUSH: the previous cycle redirected.
- Next-PC priority, highest first:
  - reset → RESET_PC.
  - jr_en → jr_target.
  - jump_en → jump_target.
  - br_taken → br_pc + 1 + br_offset.
  - stall → pc (held).
  - otherwise → pc + 1.
- Arithmetic: all PC arithmetic is 32-bit unsigned modulo 2^32. 0xFFFFFFFF + 1 wraps to 0. Negative offsets rely on the upstream sign extension; this block does no extension.
- imem_addr is pc truncated to IMEM_AW bits. The upper PC bits are kept, not cleared.
- Redirect: any of jr_en, jump_en or br_taken.
- Transitions:
  - Redirect → FLUSH.
  - Else stall → HOLD.
  - Else → RUN.
  - Transitions apply from any state.
- flush = (state == FLUSH). It is registered and glitch-free.
- Redirect and stall in the same cycle: the redirect wins. The stalled instruction is on the wrong path and is flushed.
- Redirect while in FLUSH: accepted. flush stays high one more cycle and the PC takes the new target.
- Multiple redirect enables in one cycle: resolved by the priority above. This is legal and not an error.

## Timing
- Reset values: pc = RESET_PC, imem_addr = RESET_PC[IMEM_AW-1:0], flush = 0, state = RUN.
- Reset applied mid-operation overrides every input on that edge.
- Latency, with inputs sampled in cycle N:
  - pc reflects the selected successor in cycle N+1.
  - flush is high for exactly cycle N+1 per redirect.
- Stall: pc holds for as many cycles as stall is high and resumes +1 on the first cycle after stall falls.
- No combinational path from inputs to pc or flush. imem_addr is a pure slice of pc.

## Configuration
- PC_REDIRECT_CNT_EN:
  - Defined: adds output redirect_count (out, 32 bits). It increments by 1 on each edge where a redirect is accepted and reset is low. It wraps modulo 2^32 and resets to 0.
  - Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - state encoding constants: RUN = 2'd0, HOLD = 2'd1, FLUSH = 2'd2.
  - default RESET_PC.
- One sub-module, pc_next_sel: purely combinational priority mux and adders producing next_pc and a redirect flag.
- The top level holds the PC register, the FSM and the optional counter.

## Test plan
- Reset, then 4 idle cycles → pc = 0,1,2,3,4; flush = 0 throughout.
- At pc = 10, br_taken with br_pc = 8 and br_offset = 0xFFFFFFFB (−5) → next pc = 4; flush high for exactly one cycle.
- jump_en with target 0x00000100 and br_taken asserted together → pc = 0x100 (jump wins); one flush pulse.
- stall high 3 cycles at pc = 7 → pc stays 7 for 3 cycles, then 8. With jr_en (target 0x20) during the second stall cycle → pc = 0x20 and flush pulses despite stall.
- pc = 0xFFFFFFFF, idle → pc = 0, imem_addr = 0. With the macro defined, 3 back-to-back redirects → redirect_count = 3 and flush high 3 consecutive cycles.
- Reset asserted in the cycle after a redirect → pc = RESET_PC and flush = 0 on the next cycle.
